// File: rtl/ifmap_decompressor.sv
// Zero-run-length decoder: expands {eob, run, value} tokens from 64-bit global buffer words
// into 8-lane packets offered to the ifmap buffer over a req/ack handshake.

`define IFMP_DATA_SIZE 8

package ifmap_decompressor_pkg;
    localparam int unsigned LANES  = `IFMP_DATA_SIZE;
    localparam int unsigned BYTE_W = 8;

    typedef struct packed {
        logic                         packet_valid;
        logic [LANES-1:0]             valid_mask;
        logic [LANES-1:0][BYTE_W-1:0] data;
    } DECOMRPESS_FIFO_PACKET;
endpackage

module ifmap_decompressor
    import ifmap_decompressor_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [63:0]           gb_word,
    input  logic                  gb_valid,
    output logic                  gb_ready,
    input  logic                  ifmap_req,
    output logic                  decompressor_ack,
    output DECOMRPESS_FIFO_PACKET decompressed_fifo_packet,
    output logic                  done
);

    localparam int unsigned TOK_W      = 16;
    localparam int unsigned RUN_W      = 7;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned CNT_W      = $clog2(LANES) + 1;
    localparam int unsigned LANE_IDX_W = $clog2(LANES);

    // Word register
    logic [63:0]                  r_word;
    logic [IDX_W-1:0]             r_tok_idx;
    logic                         r_word_valid;

    // Engine and accumulator
    logic [RUN_W-1:0]             r_zeros_left;
    logic [LANES-1:0][BYTE_W-1:0] r_acc_data;
    logic [CNT_W-1:0]             r_acc_cnt;

    // Output register
    DECOMRPESS_FIFO_PACKET        r_pkt;
    logic                         r_last;
    logic                         r_done;

    logic                         w_out_free;
    logic                         w_step;
    logic                         w_zero_step;
    logic                         w_val_step;
    logic                         w_last_tok;
    logic                         w_accept;
    logic                         w_eob;
    logic [BYTE_W-1:0]            w_value;
    logic [IDX_W-1:0]             w_next_idx;
    logic [RUN_W-1:0]             w_next_run;
    logic [CNT_W-1:0]             w_room;
    logic [CNT_W-1:0]             w_n;
    logic [LANES-1:0][BYTE_W-1:0] w_acc_data;
    logic [CNT_W-1:0]             w_acc_cnt;
    logic                         w_emit;
    logic [LANES-1:0]             w_mask;

    // Current token fields and handshake qualifiers
    always_comb begin
        w_out_free  = !r_pkt.packet_valid | ifmap_req;
        w_step      = r_word_valid & w_out_free;
        w_zero_step = w_step & (r_zeros_left != '0);
        w_val_step  = w_step & (r_zeros_left == '0);
        w_last_tok  = (r_tok_idx == IDX_W'(3));
        w_eob       = r_word[{r_tok_idx, 4'd15}];
        w_value     = r_word[{r_tok_idx, 4'd0} +: BYTE_W];
        w_next_idx  = r_tok_idx + IDX_W'(1);
        w_next_run  = r_word[{w_next_idx, 4'd8} +: RUN_W];
        // The word slot frees up on the value step of its final token, so
        // back-to-back words need no bubble; gb_valid never feeds this path.
        gb_ready    = !r_word_valid | (w_val_step & w_last_tok);
        w_accept    = gb_valid & gb_ready;
    end

    // Zero count for this step is limited by the lanes left in the accumulator
    always_comb begin
        w_room = CNT_W'(LANES) - r_acc_cnt;
        w_n    = (r_zeros_left < RUN_W'(w_room)) ? CNT_W'(r_zeros_left) : w_room;
    end

    // Next accumulator contents after this cycle's step
    always_comb begin
        w_acc_data = r_acc_data;
        w_acc_cnt  = r_acc_cnt;
        if (w_zero_step) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if ((CNT_W'(i) >= r_acc_cnt) && (CNT_W'(i) < r_acc_cnt + w_n)) begin
                    w_acc_data[i] = '0;
                end
            end
            w_acc_cnt = r_acc_cnt + w_n;
        end else if (w_val_step) begin
            w_acc_data[r_acc_cnt[LANE_IDX_W-1:0]] = w_value;
            w_acc_cnt = r_acc_cnt + CNT_W'(1);
        end
    end

    // Packet boundary: a full accumulator or the literal of an end-of-block token
    always_comb begin
        w_emit = (w_zero_step | w_val_step) &
                 ((w_acc_cnt == CNT_W'(LANES)) | (w_val_step & w_eob));
        for (int unsigned i = 0; i < LANES; i++) begin
            w_mask[i] = (CNT_W'(i) < w_acc_cnt);
        end
    end

    // Word register and token sequencing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word       <= '0;
            r_tok_idx    <= '0;
            r_word_valid <= 1'b0;
            r_zeros_left <= '0;
        end else if (start) begin
            r_word       <= '0;
            r_tok_idx    <= '0;
            r_word_valid <= 1'b0;
            r_zeros_left <= '0;
        end else if (w_accept) begin
            r_word       <= gb_word;
            r_tok_idx    <= '0;
            r_word_valid <= 1'b1;
            r_zeros_left <= gb_word[8 +: RUN_W];
        end else if (w_val_step) begin
            if (w_last_tok) begin
                r_word_valid <= 1'b0;
                r_zeros_left <= '0;
            end else begin
                r_tok_idx    <= w_next_idx;
                r_zeros_left <= w_next_run;
            end
        end else if (w_zero_step) begin
            r_zeros_left <= r_zeros_left - RUN_W'(w_n);
        end
    end

    // Accumulator; empties whenever its contents move to the output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc_data <= '0;
            r_acc_cnt  <= '0;
        end else if (start || w_emit) begin
            r_acc_data <= '0;
            r_acc_cnt  <= '0;
        end else begin
            r_acc_data <= w_acc_data;
            r_acc_cnt  <= w_acc_cnt;
        end
    end

    // Output register: reload has priority over the clear-on-transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt  <= '0;
            r_last <= 1'b0;
            r_done <= 1'b0;
        end else if (start) begin
            r_pkt  <= '0;
            r_last <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= ifmap_req & r_pkt.packet_valid & r_last;
            if (w_emit) begin
                r_pkt.packet_valid <= 1'b1;
                r_pkt.valid_mask   <= w_mask;
                r_pkt.data         <= w_acc_data;
                r_last             <= w_val_step & w_eob;
            end else if (ifmap_req && r_pkt.packet_valid) begin
                r_pkt  <= '0;
                r_last <= 1'b0;
            end
        end
    end

    assign decompressor_ack         = r_pkt.packet_valid;
    assign decompressed_fifo_packet = r_pkt;
    assign done                     = r_done;

endmodule

// File: tb/tb_ifmap_decompressor.sv
// Self-checking bench for ifmap_decompressor: directed scenarios plus random token streams
// compared against a byte-stream reference model.
`timescale 1ns/1ps

module tb_ifmap_decompressor;
    import ifmap_decompressor_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [63:0]           gb_word;
    logic                  gb_valid;
    logic                  gb_ready;
    logic                  ifmap_req;
    logic                  decompressor_ack;
    DECOMRPESS_FIFO_PACKET pkt;
    logic                  done;

    ifmap_decompressor dut (
        .clk                      (clk),
        .rst                      (rst),
        .start                    (start),
        .gb_word                  (gb_word),
        .gb_valid                 (gb_valid),
        .gb_ready                 (gb_ready),
        .ifmap_req                (ifmap_req),
        .decompressor_ack         (decompressor_ack),
        .decompressed_fifo_packet (pkt),
        .done                     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  mask;
        logic [63:0] data;
        bit          last;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  m_acc[$];
    logic [63:0] word_q[$];

    int   errors  = 0;
    int   checks  = 0;
    int   cyc     = 0;
    int   n_xfer  = 0;
    int   n_done  = 0;
    int   acc_cyc = 0;
    int   ack_cyc = 0;
    bit   ack_seen = 0;
    logic exp_done = 1'b0;
    int   req_mode = 1;
    bit   feed_en  = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] tok(input bit eob, input int run, input logic [7:0] v);
        return {eob, 7'(run), v};
    endfunction

    // Reference: bytes stream into 8-lane packets, flushed when full or at end of block
    function automatic void m_push(input logic [7:0] b, input bit eob);
        exp_t e;
        m_acc.push_back(b);
        if (m_acc.size() == 8 || eob) begin
            e.mask = 8'((1 << m_acc.size()) - 1);
            e.data = '0;
            foreach (m_acc[i]) e.data[8*i +: 8] = m_acc[i];
            e.last = eob;
            exp_q.push_back(e);
            m_acc.delete();
        end
    endfunction

    function automatic void m_word(input logic [63:0] w);
        logic [15:0] t;
        for (int k = 0; k < 4; k++) begin
            t = w[16*k +: 16];
            for (int z = 0; z < int'(t[14:8]); z++) m_push(8'h00, 1'b0);
            m_push(t[7:0], t[15]);
        end
    endfunction

    function automatic void m_clear();
        exp_q.delete();
        m_acc.delete();
    endfunction

    // One clock: observe handshakes at the falling edge, then drive the next inputs
    task automatic tick();
        exp_t e;
        @(negedge clk);
        chk("done", done, exp_done);
        if (done) n_done++;
        exp_done = 1'b0;
        if (decompressor_ack && !ack_seen) begin
            ack_seen = 1;
            ack_cyc  = cyc;
        end
        if (ifmap_req && decompressor_ack && !start) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                chk("unexpected_pkt", 64'(pkt.valid_mask), 64'h0);
            end else begin
                e = exp_q.pop_front();
                chk("pkt_mask", 64'(pkt.valid_mask), 64'(e.mask));
                chk("pkt_data", pkt.data, e.data);
                exp_done = e.last;
            end
        end
        if (gb_valid && gb_ready && !start) begin
            m_word(word_q.pop_front());
            acc_cyc = cyc;
        end
        if (start) m_clear();
        @(posedge clk);
        #1;
        start = 1'b0;
        case (req_mode)
            0:       ifmap_req = 1'b0;
            1:       ifmap_req = 1'b1;
            default: ifmap_req = ($urandom_range(0, 3) != 0);
        endcase
        if (feed_en && word_q.size() > 0 && (req_mode != 2 || $urandom_range(0, 3) != 0)) begin
            gb_valid = 1'b1;
            gb_word  = word_q[0];
        end else begin
            gb_valid = 1'b0;
            gb_word  = {$urandom, $urandom};
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 5000; i++) begin
            if (exp_q.size() == 0 && word_q.size() == 0 && !decompressor_ack) break;
            tick();
        end
        chk("drain_timeout", 64'(exp_q.size() + word_q.size()), 64'h0);
        repeat (3) tick();
    endtask

    task automatic do_start();
        start     = 1'b1;
        ifmap_req = 1'b0;
        gb_valid  = 1'b0;
        tick();
    endtask

    initial begin
        int x0;
        int d0;
        DECOMRPESS_FIFO_PACKET snap;

        rst       = 1'b1;
        start     = 1'b0;
        gb_valid  = 1'b0;
        gb_word   = '0;
        ifmap_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset values
        chk("rst_gb_ready", gb_ready, 1'b1);
        chk("rst_ack", decompressor_ack, 1'b0);
        chk("rst_pkt_valid", pkt.packet_valid, 1'b0);
        chk("rst_mask", 64'(pkt.valid_mask), 64'h0);
        chk("rst_data", pkt.data, 64'h0);
        chk("rst_done", done, 1'b0);

        // Requests with no input stay idle
        req_mode  = 1;
        ifmap_req = 1'b1;
        repeat (5) tick();
        chk("idle_ack", decompressor_ack, 1'b0);
        chk("idle_gb_ready", gb_ready, 1'b1);

        // Two packets from one word, the second closing the block
        x0 = n_xfer;
        d0 = n_done;
        word_q.push_back({tok(0, 0, 8'h00), tok(1, 0, 8'h33), tok(0, 10, 8'h22), tok(0, 3, 8'h11)});
        drain();
        chk("t1_xfers", 64'(n_xfer - x0), 64'd2);
        chk("t1_done_pulses", 64'(n_done - d0), 64'd1);
        do_start();

        // Short block and accept-to-ack latency (ack visible after E0+2)
        x0 = n_xfer;
        ack_seen = 0;
        word_q.push_back({tok(0, 0, 8'h00), tok(0, 0, 8'h00), tok(0, 0, 8'h00), tok(1, 2, 8'h7F)});
        drain();
        chk("t3_xfers", 64'(n_xfer - x0), 64'd1);
        chk("t3_latency", 64'(ack_cyc - acc_cyc), 64'd3);
        do_start();

        // Back-pressure: packet held stable and word register stays full
        x0 = n_xfer;
        req_mode = 0;
        word_q.push_back({tok(0, 7, 8'hA3), tok(0, 7, 8'hA2), tok(0, 7, 8'hA1), tok(0, 7, 8'hA0)});
        word_q.push_back({tok(0, 7, 8'hB3), tok(0, 7, 8'hB2), tok(0, 7, 8'hB1), tok(0, 7, 8'hB0)});
        repeat (8) tick();
        chk("t4_ack", decompressor_ack, 1'b1);
        snap = pkt;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_hold_data", pkt.data, snap.data);
            chk("t4_hold_mask", 64'(pkt.valid_mask), 64'(snap.valid_mask));
            chk("t4_gb_ready", gb_ready, 1'b0);
        end
        req_mode = 1;
        drain();
        chk("t4_xfers", 64'(n_xfer - x0), 64'd8);

        // Maximum run length spanning many packets
        x0 = n_xfer;
        word_q.push_back({tok(0, 0, 8'h00), tok(0, 0, 8'h00), tok(1, 1, 8'h01), tok(0, 127, 8'h00)});
        drain();
        chk("t5_xfers", 64'(n_xfer - x0), 64'd17);
        do_start();

        // Clear while a packet is pending
        req_mode = 0;
        word_q.push_back({tok(0, 7, 8'hC3), tok(0, 7, 8'hC2), tok(0, 7, 8'hC1), tok(0, 7, 8'hC0)});
        for (int i = 0; i < 20; i++) begin
            if (decompressor_ack) break;
            tick();
        end
        chk("t6_pending", decompressor_ack, 1'b1);
        do_start();
        chk("t6_ack_cleared", decompressor_ack, 1'b0);
        chk("t6_gb_ready", gb_ready, 1'b1);
        x0 = n_xfer;
        req_mode = 1;
        word_q.push_back({tok(0, 0, 8'h00), tok(0, 0, 8'h00), tok(0, 0, 8'h00), tok(1, 0, 8'h55)});
        drain();
        chk("t6_xfers", 64'(n_xfer - x0), 64'd1);
        do_start();

        // Random token streams with random back-pressure
        req_mode = 2;
        for (int w = 0; w < 300; w++) begin
            logic [63:0] word;
            for (int k = 0; k < 4; k++) begin
                word[16*k +: 16] = tok($urandom_range(0, 3) == 0,
                                       ($urandom_range(0, 7) == 0) ? $urandom_range(0, 127)
                                                                   : $urandom_range(0, 10),
                                       8'($urandom));
            end
            word_q.push_back(word);
        end
        for (int i = 0; i < 40000; i++) begin
            if (word_q.size() == 0) break;
            tick();
        end
        chk("rand_feed_timeout", 64'(word_q.size()), 64'h0);
        req_mode = 1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
